// File: rtl/datamem_arbiter.sv
// datamem_arbiter
//   Shares the single-port, byte-addressed data memory between the core
//   load/store path and the debug/loader port. It grants at most one request
//   per cycle, issues it as one memory command, and returns the response to
//   the owning requester one cycle later. The core has priority. A starvation
//   counter forces a debug grant after STARVE_LIMIT consecutive blocked debug
//   cycles. Misaligned requests are accepted but never reach the memory; they
//   are answered with an error response.
//
// Ports
//   clk, rst_n              clock; synchronous active-low reset
//   core_req_* / dbg_req_*  request channels (valid/ready, wr, addr, funct3, wdata)
//   core_rsp_* / dbg_rsp_*  response channels (valid, err, rdata)
//   mem_en/wr/addr/funct3/wdata  command to the memory
//   mem_rdata               load result, valid the cycle after a read command
module datamem_arbiter #(
    parameter int ADDR_W       = 7,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic              core_req_wr,
    input  logic [ADDR_W-1:0] core_req_addr,
    input  logic [2:0]        core_req_funct3,
    input  logic [31:0]       core_req_wdata,
    output logic              core_rsp_valid,
    output logic              core_rsp_err,
    output logic [31:0]       core_rsp_rdata,

    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_wr,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [2:0]        dbg_req_funct3,
    input  logic [31:0]       dbg_req_wdata,
    output logic              dbg_rsp_valid,
    output logic              dbg_rsp_err,
    output logic [31:0]       dbg_rsp_rdata,

    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_funct3,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        funct3;
        logic [31:0]       wdata;
    } req_t;

    // Undefined size codes (011, 110, 111) are rejected like misaligned ones.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = a[0];
            3'b010:         misaligned = |a;
            default:        misaligned = 1'b1;
        endcase
    endfunction

    logic [3:0] starve_q;
    logic       rsp_pending_q;
    logic       rsp_owner_q;     // 0 = core, 1 = debug
    logic       rsp_err_q;
    logic       rsp_is_read_q;

    logic       gnt_core, gnt_dbg, any_gnt, sel_mis;
    req_t       core_req, dbg_req, sel;

    assign core_req = '{wr: core_req_wr, addr: core_req_addr,
                        funct3: core_req_funct3, wdata: core_req_wdata};
    assign dbg_req  = '{wr: dbg_req_wr, addr: dbg_req_addr,
                        funct3: dbg_req_funct3, wdata: dbg_req_wdata};

    // Debug wins when starved or when the core is idle; reset gates all grants.
    assign gnt_dbg  = rst_n && dbg_req_valid && (starve_q == LIMIT || !core_req_valid);
    assign gnt_core = rst_n && core_req_valid && !gnt_dbg;
    assign any_gnt  = gnt_core || gnt_dbg;

    assign core_req_ready = gnt_core;
    assign dbg_req_ready  = gnt_dbg;

    assign sel     = gnt_dbg ? dbg_req : core_req;
    assign sel_mis = misaligned(sel.funct3, sel.addr[1:0]);

    assign mem_en     = any_gnt && !sel_mis;
    assign mem_wr     = sel.wr;
    assign mem_addr   = sel.addr;
    assign mem_funct3 = sel.funct3;
    assign mem_wdata  = sel.wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q      <= 4'd0;
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_is_read_q <= 1'b0;
        end else begin
            if (!dbg_req_valid || gnt_dbg)
                starve_q <= 4'd0;
            else if (starve_q != LIMIT)
                starve_q <= starve_q + 4'd1;

            rsp_pending_q <= any_gnt;
            if (any_gnt) begin
                rsp_owner_q   <= gnt_dbg;
                rsp_err_q     <= sel_mis;
                rsp_is_read_q <= !sel.wr;
            end
        end
    end

    // Responses are also gated by reset so that a response pending at the
    // reset edge is never presented, even in the cycle reset is raised.
    logic        rsp_live;
    logic [31:0] rsp_data;

    assign rsp_live = rst_n && rsp_pending_q;
    assign rsp_data = (rsp_is_read_q && !rsp_err_q) ? mem_rdata : 32'd0;

    assign core_rsp_valid = rsp_live && !rsp_owner_q;
    assign dbg_rsp_valid  = rsp_live &&  rsp_owner_q;
    assign core_rsp_err   = core_rsp_valid && rsp_err_q;
    assign dbg_rsp_err    = dbg_rsp_valid  && rsp_err_q;
    assign core_rsp_rdata = core_rsp_valid ? rsp_data : 32'd0;
    assign dbg_rsp_rdata  = dbg_rsp_valid  ? rsp_data : 32'd0;

endmodule

// File: tb/tb_datamem_arbiter.sv
module tb_datamem_arbiter;

    localparam int AW    = 7;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_req_valid, core_req_ready, core_req_wr;
    logic [AW-1:0] core_req_addr;
    logic [2:0]    core_req_funct3;
    logic [31:0]   core_req_wdata;
    logic          core_rsp_valid, core_rsp_err;
    logic [31:0]   core_rsp_rdata;
    logic          dbg_req_valid, dbg_req_ready, dbg_req_wr;
    logic [AW-1:0] dbg_req_addr;
    logic [2:0]    dbg_req_funct3;
    logic [31:0]   dbg_req_wdata;
    logic          dbg_rsp_valid, dbg_rsp_err;
    logic [31:0]   dbg_rsp_rdata;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_funct3;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    datamem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_wr(core_req_wr), .core_req_addr(core_req_addr),
        .core_req_funct3(core_req_funct3), .core_req_wdata(core_req_wdata),
        .core_rsp_valid(core_rsp_valid), .core_rsp_err(core_rsp_err),
        .core_rsp_rdata(core_rsp_rdata),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_wr(dbg_req_wr), .dbg_req_addr(dbg_req_addr),
        .dbg_req_funct3(dbg_req_funct3), .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_err(dbg_rsp_err),
        .dbg_rsp_rdata(dbg_rsp_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_funct3(mem_funct3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sign/zero extension as the memory performs it.
    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  ext = {24'd0, raw[7:0]};
            3'b101:  ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    endfunction

    function automatic logic bad_align(input logic [2:0] f3, input logic [AW-1:0] a);
        if (f3 == 3'b000 || f3 == 3'b100) bad_align = 1'b0;
        else if (f3 == 3'b001 || f3 == 3'b101) bad_align = (a[0] != 1'b0);
        else if (f3 == 3'b010) bad_align = (a[1:0] != 2'b00);
        else bad_align = 1'b1;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Memory environment: driven only by the DUT's command port.
    logic [7:0]  env_mem [0:127] = '{default: 8'h00};
    logic [31:0] rd_q = 32'd0;
    assign mem_rdata = rd_q;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) begin
                for (int i = 0; i < nbytes(mem_funct3); i++)
                    env_mem[7'(mem_addr + i)] <= mem_wdata[8*i +: 8];
            end else begin
                rd_q <= ext(mem_funct3, {env_mem[7'(mem_addr + 3)], env_mem[7'(mem_addr + 2)],
                                         env_mem[7'(mem_addr + 1)], env_mem[mem_addr]});
            end
        end
    end

    // Scoreboard: expected response pushed at grant, popped one cycle later.
    typedef struct {
        logic        owner;   // 0 core, 1 debug
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  ref_mem [0:127] = '{default: 8'h00};
    logic [3:0]  st_model = 4'd0;

    always @(negedge clk) begin
        exp_t        e;
        logic        gd, gc, w, m;
        logic [AW-1:0] a;
        logic [2:0]  f;
        logic [31:0] wd;
        if (!rst_n) begin
            chk("rst_core_ready", core_req_ready, 0);
            chk("rst_dbg_ready",  dbg_req_ready, 0);
            chk("rst_mem_en",     mem_en, 0);
            chk("rst_core_rsp_valid", core_rsp_valid, 0);
            chk("rst_dbg_rsp_valid",  dbg_rsp_valid, 0);
            sb.delete();
            st_model = 4'd0;
        end else begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_core_valid", core_rsp_valid, !e.owner);
                chk("rsp_dbg_valid",  dbg_rsp_valid, e.owner);
                chk("rsp_err",   e.owner ? dbg_rsp_err : core_rsp_err, e.err);
                chk("rsp_rdata", e.owner ? dbg_rsp_rdata : core_rsp_rdata, e.rdata);
            end else begin
                chk("idle_core_rsp_valid", core_rsp_valid, 0);
                chk("idle_dbg_rsp_valid",  dbg_rsp_valid, 0);
            end
            gd = dbg_req_valid && (st_model == 4'(LIMIT) || !core_req_valid);
            gc = core_req_valid && !gd;
            chk("core_ready", core_req_ready, gc);
            chk("dbg_ready",  dbg_req_ready, gd);
            if (gc || gd) begin
                w  = gd ? dbg_req_wr : core_req_wr;
                a  = gd ? dbg_req_addr : core_req_addr;
                f  = gd ? dbg_req_funct3 : core_req_funct3;
                wd = gd ? dbg_req_wdata : core_req_wdata;
                m  = bad_align(f, a);
                chk("mem_en", mem_en, !m);
                e.owner = gd;
                e.err   = m;
                e.rdata = 32'd0;
                if (!m) begin
                    chk("mem_addr", mem_addr, a);
                    chk("mem_wr",   mem_wr, w);
                    if (w) begin
                        for (int i = 0; i < nbytes(f); i++)
                            ref_mem[7'(a + i)] = wd[8*i +: 8];
                    end else begin
                        e.rdata = ext(f, {ref_mem[7'(a + 3)], ref_mem[7'(a + 2)],
                                          ref_mem[7'(a + 1)], ref_mem[a]});
                    end
                end
                sb.push_back(e);
            end else begin
                chk("no_grant_mem_en", mem_en, 0);
            end
            if (!dbg_req_valid || gd) st_model = 4'd0;
            else if (st_model != 4'(LIMIT)) st_model = st_model + 4'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic core_req(input logic wr, input logic [AW-1:0] a, input logic [2:0] f,
                            input logic [31:0] wd);
        core_req_valid = 1'b1; core_req_wr = wr; core_req_addr = a;
        core_req_funct3 = f; core_req_wdata = wd;
    endtask

    task automatic dbg_req(input logic wr, input logic [AW-1:0] a, input logic [2:0] f,
                           input logic [31:0] wd);
        dbg_req_valid = 1'b1; dbg_req_wr = wr; dbg_req_addr = a;
        dbg_req_funct3 = f; dbg_req_wdata = wd;
    endtask

    task automatic core_idle();
        core_req_valid = 1'b0; core_req_wr = 1'b0; core_req_addr = '0;
        core_req_funct3 = 3'b000; core_req_wdata = 32'd0;
    endtask

    task automatic dbg_idle();
        dbg_req_valid = 1'b0; dbg_req_wr = 1'b0; dbg_req_addr = '0;
        dbg_req_funct3 = 3'b000; dbg_req_wdata = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        core_idle();
        dbg_idle();
        step();
        @(negedge clk);
        chk("reset_starve", dut.starve_q, 0);
        chk("reset_core_rdata", core_rsp_rdata, 0);
        chk("reset_dbg_err", dbg_rsp_err, 0);
        step();
        rst_n = 1'b1;
        step();

        // Core store W then load W back-to-back
        core_req(1'b1, 7'h10, 3'b010, 32'hDEADBEEF);
        step();
        core_req(1'b0, 7'h10, 3'b010, 32'd0);
        @(negedge clk);
        chk("core_store_rdata", core_rsp_rdata, 32'h0);
        chk("core_store_valid", core_rsp_valid, 1);
        step();
        core_idle();
        @(negedge clk);
        chk("core_load_w", core_rsp_rdata, 32'hDEADBEEF);
        chk("core_load_err", core_rsp_err, 0);
        step();

        // Debug load BU from 0x13
        dbg_req(1'b0, 7'h13, 3'b100, 32'd0);
        step();
        dbg_idle();
        @(negedge clk);
        chk("dbg_load_bu", dbg_rsp_rdata, 32'h000000DE);
        chk("dbg_load_core_quiet", core_rsp_valid, 0);
        step();

        // Contention: debug blocked 4 cycles, granted in the 5th
        core_req(1'b0, 7'h10, 3'b010, 32'd0);
        dbg_req(1'b0, 7'h10, 3'b000, 32'd0);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("cont_starve_%0d", i), dut.starve_q, i);
            chk($sformatf("cont_dbg_ready_%0d", i), dbg_req_ready, (i == 4));
            chk($sformatf("cont_core_ready_%0d", i), core_req_ready, (i != 4));
            step();
        end
        dbg_idle();
        @(negedge clk);
        chk("cont_core_after", core_req_ready, 1);
        chk("cont_starve_clr", dut.starve_q, 0);
        chk("cont_dbg_rsp", dbg_rsp_rdata, 32'hFFFFFFEF);
        step();

        // Misaligned accesses leave memory untouched
        core_req(1'b1, 7'h04, 3'b010, 32'h11223344);
        step();
        core_req(1'b0, 7'h02, 3'b010, 32'd0);
        @(negedge clk);
        chk("mis_w_mem_en", mem_en, 0);
        step();
        core_req(1'b1, 7'h05, 3'b001, 32'h0000FFFF);
        @(negedge clk);
        chk("mis_w_err", core_rsp_err, 1);
        chk("mis_w_rdata", core_rsp_rdata, 0);
        chk("mis_h_mem_en", mem_en, 0);
        step();
        core_req(1'b0, 7'h00, 3'b011, 32'd0);
        @(negedge clk);
        chk("mis_h_err", core_rsp_err, 1);
        step();
        core_req(1'b0, 7'h04, 3'b010, 32'd0);
        @(negedge clk);
        chk("bad_f3_err", core_rsp_err, 1);
        step();
        core_idle();
        @(negedge clk);
        chk("mem_unchanged", core_rsp_rdata, 32'h11223344);
        step();

        // Reset in the cycle after a load grant
        core_req(1'b0, 7'h10, 3'b010, 32'd0);
        dbg_req(1'b0, 7'h13, 3'b100, 32'd0);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_starve_pre", dut.starve_q, 1);
        step();
        @(negedge clk);
        chk("rst_mid_starve", dut.starve_q, 0);
        chk("rst_mid_pending", dut.rsp_pending_q, 0);
        step();
        rst_n = 1'b1;
        core_idle();
        dbg_idle();
        @(negedge clk);
        chk("rst_drop_core", core_rsp_valid, 0);
        chk("rst_drop_dbg", dbg_rsp_valid, 0);
        step();

        // Simultaneous requests with starve_q = 0
        core_req(1'b1, 7'h20, 3'b000, 32'h000000AA);
        dbg_req(1'b1, 7'h21, 3'b000, 32'h00000055);
        @(negedge clk);
        chk("simul_core_ready", core_req_ready, 1);
        chk("simul_dbg_ready", dbg_req_ready, 0);
        step();
        core_idle();
        @(negedge clk);
        chk("simul_starve", dut.starve_q, 1);
        chk("simul_dbg_next", dbg_req_ready, 1);
        step();
        dbg_idle();
        core_req(1'b0, 7'h20, 3'b001, 32'd0);
        step();
        core_idle();
        @(negedge clk);
        chk("simul_readback", core_rsp_rdata, 32'h000055AA);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
